// File: rtl/pq_rr_arb_if.sv
// Bundles the client request/ack/response signals and the priority-queue port
// of pq_rr_arb; slave is the arbiter side, master the clients + queue side.
interface pq_rr_arb_if #(
  parameter int N_CLIENTS = 4,
  parameter int KVW       = 16,
  parameter int CW        = 4
);
  logic [N_CLIENTS-1:0]     enq_req;
  logic [N_CLIENTS*KVW-1:0] enq_kv;
  logic [N_CLIENTS-1:0]     enq_ack;
  logic [N_CLIENTS-1:0]     deq_req;
  logic [N_CLIENTS-1:0]     deq_ack;
  logic [N_CLIENTS-1:0]     deq_rsp_valid;
  logic [KVW-1:0]           deq_rsp_kv;
  logic [KVW-1:0]           pq_kvi;
  logic                     pq_enq;
  logic                     pq_deq;
  logic [KVW-1:0]           pq_kvo;
  logic                     pq_empty;
  logic                     pq_full;
  logic [CW-1:0]            count;

  modport slave (
    input  enq_req, enq_kv, deq_req, pq_kvo, pq_empty, pq_full,
    output enq_ack, deq_ack, deq_rsp_valid, deq_rsp_kv, pq_kvi, pq_enq, pq_deq, count
  );

  modport master (
    output enq_req, enq_kv, deq_req, pq_kvo, pq_empty, pq_full,
    input  enq_ack, deq_ack, deq_rsp_valid, deq_rsp_kv, pq_kvi, pq_enq, pq_deq, count
  );
endinterface

// File: rtl/pq_rr_arb.sv
// Shares one priority queue between N_CLIENTS requesters with independent
// round-robin enqueue/dequeue arbiters; dequeued words return one cycle later.
module pq_rr_arb #(
  parameter int N_CLIENTS = 4,
  parameter int DEPTH     = 8,
  parameter int KEY_WIDTH = 8,
  parameter int VAL_WIDTH = 8,
  parameter int KVW       = KEY_WIDTH + VAL_WIDTH,
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input logic         clk,
  input logic         rst,
  pq_rr_arb_if.slave  bus
);
  localparam int PW = $clog2(N_CLIENTS);

  logic [PW-1:0]        enqPtr_q, enqPtr_d;
  logic [PW-1:0]        deqPtr_q, deqPtr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [N_CLIENTS-1:0] rspValid_q, rspValid_d;
  logic [KVW-1:0]       rspKv_q, rspKv_d;
  logic [PW-1:0]        enqWin, deqWin;
  logic                 enqAny, deqAny, doEnq, doDeq;

  // Lowest requester overall, overridden by the lowest one at or above the pointer.
  function automatic logic [PW-1:0] pickRr(input logic [N_CLIENTS-1:0] req,
                                           input logic [PW-1:0] ptr);
    logic [PW-1:0] win;
    win = '0;
    for (int k = N_CLIENTS - 1; k >= 0; k--)
      if (req[k]) win = PW'(k);
    for (int k = N_CLIENTS - 1; k >= 0; k--)
      if (req[k] && (PW'(k) >= ptr)) win = PW'(k);
    return win;
  endfunction

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] g);
    return (g == PW'(N_CLIENTS - 1)) ? '0 : g + 1'b1;
  endfunction

  // Dequeue is decided first: a full queue still accepts an enqueue paired with a dequeue.
  always_comb begin
    enqWin = pickRr(bus.enq_req, enqPtr_q);
    deqWin = pickRr(bus.deq_req, deqPtr_q);
    enqAny = |bus.enq_req;
    deqAny = |bus.deq_req;
    doDeq  = deqAny && !bus.pq_empty;
    doEnq  = enqAny && (!bus.pq_full || doDeq);
  end

  always_comb begin
    bus.pq_enq  = doEnq;
    bus.pq_deq  = doDeq;
    bus.pq_kvi  = '0;
    bus.enq_ack = '0;
    bus.deq_ack = '0;
    if (doEnq) begin
      bus.pq_kvi          = bus.enq_kv[int'(enqWin)*KVW +: KVW];
      bus.enq_ack[enqWin] = 1'b1;
    end
    if (doDeq) begin
      bus.deq_ack[deqWin] = 1'b1;
    end
  end

  always_comb begin
    enqPtr_d   = doEnq ? nextPtr(enqWin) : enqPtr_q;
    deqPtr_d   = doDeq ? nextPtr(deqWin) : deqPtr_q;
    rspValid_d = '0;
    if (doDeq) rspValid_d[deqWin] = 1'b1;
    rspKv_d    = doDeq ? bus.pq_kvo : rspKv_q;
    case ({doEnq, doDeq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enqPtr_q   <= '0;
      deqPtr_q   <= '0;
      count_q    <= '0;
      rspValid_q <= '0;
      rspKv_q    <= '0;
    end else begin
      enqPtr_q   <= enqPtr_d;
      deqPtr_q   <= deqPtr_d;
      count_q    <= count_d;
      rspValid_q <= rspValid_d;
      rspKv_q    <= rspKv_d;
    end
  end

  assign bus.count         = count_q;
  assign bus.deq_rsp_valid = rspValid_q;
  assign bus.deq_rsp_kv    = rspKv_q;
endmodule

// File: tb/tb_pq_rr_arb.sv
// Self-checking bench for pq_rr_arb: directed scenarios plus random traffic
// against a reference model that also stands in for the attached queue.
module tb_pq_rr_arb;
  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int KW    = 8;
  localparam int VW    = 8;
  localparam int KVW   = KW + VW;
  localparam int CW    = $clog2(DEPTH + 1);

  logic           clk, rst;
  logic [N-1:0]   enqReq, deqReq;
  logic [N*KVW-1:0] enqKv;
  logic [KVW-1:0] pqKvo;
  logic           pqEmpty, pqFull;

  pq_rr_arb_if #(.N_CLIENTS(N), .KVW(KVW), .CW(CW)) bus ();

  assign bus.enq_req  = enqReq;
  assign bus.enq_kv   = enqKv;
  assign bus.deq_req  = deqReq;
  assign bus.pq_kvo   = pqKvo;
  assign bus.pq_empty = pqEmpty;
  assign bus.pq_full  = pqFull;

  pq_rr_arb #(.N_CLIENTS(N), .DEPTH(DEPTH), .KEY_WIDTH(KW), .VAL_WIDTH(VW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  // Reference model: queue contents in insertion order, pointers as plain integers.
  logic [KVW-1:0] mQ[$];
  int             mEnqPtr, mDeqPtr;
  logic [N-1:0]   mRspValid;
  logic [KVW-1:0] mRspKv;

  int             eEnqWin, eDeqWin;
  bit             eDoEnq, eDoDeq, eEnqFound;
  logic [N-1:0]   eEnqAck, eDeqAck;
  logic [KVW-1:0] ePqKvi;

  logic [N-1:0]   oEnqAck, oDeqAck, oRspValid;
  logic           oPqEnq, oPqDeq;
  logic [KVW-1:0] oPqKvi, oRspKv;
  logic [CW-1:0]  oCount;

  function automatic int headIdx();
    int best = 0;
    for (int i = 1; i < mQ.size(); i++)
      if (mQ[i][KVW-1 -: KW] < mQ[best][KVW-1 -: KW]) best = i;
    return best;
  endfunction

  function automatic int rrPick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic driveQueueView();
    pqEmpty = (mQ.size() == 0);
    pqFull  = (mQ.size() == DEPTH);
    pqKvo   = pqEmpty ? '0 : mQ[headIdx()];
  endtask

  task automatic modelReset();
    enqReq = '0; deqReq = '0; enqKv = '0;
    mQ.delete();
    mEnqPtr = 0; mDeqPtr = 0;
    mRspValid = '0; mRspKv = '0;
    driveQueueView();
  endtask

  task automatic applyReset();
    rst = 1'b1;
    modelReset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic setEnq(input int c, input logic [KW-1:0] k, input logic [VW-1:0] v);
    enqReq[c] = 1'b1;
    enqKv[c*KVW +: KVW] = {k, v};
  endtask

  // One clock: predict, sample combinational outputs mid-cycle, advance model, sample registers.
  task automatic applyStimulus();
    int h;
    driveQueueView();
    eEnqWin   = rrPick(enqReq, mEnqPtr);
    eDeqWin   = rrPick(deqReq, mDeqPtr);
    eEnqFound = (eEnqWin >= 0);
    eDoDeq    = (eDeqWin >= 0) && !pqEmpty;
    eDoEnq    = eEnqFound && (!pqFull || eDoDeq);
    eEnqAck   = '0; eDeqAck = '0; ePqKvi = '0;
    if (eDoEnq) begin
      eEnqAck[eEnqWin] = 1'b1;
      ePqKvi = enqKv[eEnqWin*KVW +: KVW];
    end
    if (eDoDeq) eDeqAck[eDeqWin] = 1'b1;
    @(negedge clk);
    oEnqAck = bus.enq_ack; oDeqAck = bus.deq_ack;
    oPqEnq  = bus.pq_enq;  oPqDeq  = bus.pq_deq; oPqKvi = bus.pq_kvi;
    @(posedge clk); #1;
    mRspValid = eDeqAck;
    if (eDoDeq) begin
      h = headIdx();
      mRspKv = mQ[h];
      mQ.delete(h);
      mDeqPtr = (eDeqWin + 1) % N;
      deqReq[eDeqWin] = 1'b0;
    end
    if (eDoEnq) begin
      mQ.push_back(enqKv[eEnqWin*KVW +: KVW]);
      mEnqPtr = (eEnqWin + 1) % N;
      enqReq[eEnqWin] = 1'b0;
    end
    oRspValid = bus.deq_rsp_valid; oRspKv = bus.deq_rsp_kv; oCount = bus.count;
    driveQueueView();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    modelReset();
    #2;
    nTests++; if (bus.count !== '0) begin nFail++; $display("[TB] FAIL reset_count: got %0d want 0", bus.count); end
    nTests++; if (bus.deq_rsp_valid !== '0) begin nFail++; $display("[TB] FAIL reset_rsp_valid: got %b want 0000", bus.deq_rsp_valid); end
    nTests++; if (bus.deq_rsp_kv !== '0) begin nFail++; $display("[TB] FAIL reset_rsp_kv: got %h want 0", bus.deq_rsp_kv); end
    nTests++; if ({bus.enq_ack, bus.deq_ack, bus.pq_enq, bus.pq_deq} !== '0) begin nFail++; $display("[TB] FAIL reset_comb: got %b/%b/%b/%b want all 0", bus.enq_ack, bus.deq_ack, bus.pq_enq, bus.pq_deq); end
    nTests++; if (bus.pq_kvi !== '0) begin nFail++; $display("[TB] FAIL reset_kvi: got %h want 0", bus.pq_kvi); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    applyReset();
    setEnq(0, 8'd8, 8'd14);
    applyStimulus();
    nTests++; if (oEnqAck !== 4'b0001) begin nFail++; $display("[TB] FAIL basic_enq_ack: got %b want 0001", oEnqAck); end
    nTests++; if (oPqEnq !== 1'b1) begin nFail++; $display("[TB] FAIL basic_pq_enq: got %b want 1", oPqEnq); end
    nTests++; if (oPqKvi !== {8'd8, 8'd14}) begin nFail++; $display("[TB] FAIL basic_pq_kvi: got %h want 080e", oPqKvi); end
    nTests++; if (oCount !== 4'd1) begin nFail++; $display("[TB] FAIL basic_count_up: got %0d want 1", oCount); end
    deqReq[1] = 1'b1;
    applyStimulus();
    nTests++; if (oDeqAck !== 4'b0010) begin nFail++; $display("[TB] FAIL basic_deq_ack: got %b want 0010", oDeqAck); end
    nTests++; if (oPqEnq !== 1'b0) begin nFail++; $display("[TB] FAIL basic_pq_enq_pulse: got %b want 0", oPqEnq); end
    nTests++; if (oRspValid !== 4'b0010) begin nFail++; $display("[TB] FAIL basic_rsp_valid: got %b want 0010", oRspValid); end
    nTests++; if (oRspKv !== {8'd8, 8'd14}) begin nFail++; $display("[TB] FAIL basic_rsp_kv: got %h want 080e", oRspKv); end
    nTests++; if (oCount !== 4'd0) begin nFail++; $display("[TB] FAIL basic_count_down: got %0d want 0", oCount); end
    applyStimulus();
    nTests++; if (oRspValid !== 4'b0000) begin nFail++; $display("[TB] FAIL basic_rsp_one_cycle: got %b want 0000", oRspValid); end
    nTests++; if (oRspKv !== {8'd8, 8'd14}) begin nFail++; $display("[TB] FAIL basic_rsp_hold: got %h want 080e", oRspKv); end
  endtask

  task automatic test_rr_order();
    applyReset();
    setEnq(0, 8'd9, 8'd1); setEnq(1, 8'd9, 8'd2); setEnq(2, 8'd9, 8'd3); setEnq(3, 8'd2, 8'd4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      nTests++; if (oEnqAck !== 4'(1 << i)) begin nFail++; $display("[TB] FAIL rr_order_%0d: got %b want %b", i, oEnqAck, 4'(1 << i)); end
    end
    nTests++; if (oCount !== 4'd4) begin nFail++; $display("[TB] FAIL rr_count: got %0d want 4", oCount); end
    setEnq(0, 8'd9, 8'd5); setEnq(2, 8'd9, 8'd6);
    applyStimulus();
    nTests++; if (oEnqAck !== 4'b0001) begin nFail++; $display("[TB] FAIL rr_wrap_first: got %b want 0001", oEnqAck); end
    applyStimulus();
    nTests++; if (oEnqAck !== 4'b0100) begin nFail++; $display("[TB] FAIL rr_wrap_second: got %b want 0100", oEnqAck); end
  endtask

  task automatic test_full();
    setEnq(1, 8'd10, 8'd7); setEnq(3, 8'd11, 8'd8);
    applyStimulus();
    applyStimulus();
    nTests++; if (oCount !== 4'd8) begin nFail++; $display("[TB] FAIL full_count: got %0d want 8", oCount); end
    setEnq(0, 8'd12, 8'd9);
    applyStimulus();
    nTests++; if (oEnqAck !== 4'b0000 || oPqEnq !== 1'b0) begin nFail++; $display("[TB] FAIL full_block: got ack %b enq %b want 0000/0", oEnqAck, oPqEnq); end
    nTests++; if (oCount !== 4'd8) begin nFail++; $display("[TB] FAIL full_hold: got %0d want 8", oCount); end
    deqReq[1] = 1'b1;
    applyStimulus();
    nTests++; if ({oPqEnq, oPqDeq} !== 2'b11) begin nFail++; $display("[TB] FAIL full_replace: got enq/deq %b want 11", {oPqEnq, oPqDeq}); end
    nTests++; if (oEnqAck !== 4'b0001 || oDeqAck !== 4'b0010) begin nFail++; $display("[TB] FAIL full_replace_acks: got %b/%b want 0001/0010", oEnqAck, oDeqAck); end
    nTests++; if (oCount !== 4'd8) begin nFail++; $display("[TB] FAIL full_replace_count: got %0d want 8", oCount); end
    nTests++; if (oRspKv[KVW-1 -: KW] !== 8'd2) begin nFail++; $display("[TB] FAIL full_replace_min: got key %0d want 2", oRspKv[KVW-1 -: KW]); end
  endtask

  task automatic test_empty_both();
    applyReset();
    setEnq(2, 8'd1, 8'd11);
    deqReq[2] = 1'b1;
    applyStimulus();
    nTests++; if (oEnqAck !== 4'b0100 || oDeqAck !== 4'b0000 || oPqDeq !== 1'b0) begin nFail++; $display("[TB] FAIL empty_enq_only: got %b/%b deq %b want 0100/0000/0", oEnqAck, oDeqAck, oPqDeq); end
    applyStimulus();
    nTests++; if (oDeqAck !== 4'b0100 || oPqEnq !== 1'b0) begin nFail++; $display("[TB] FAIL empty_deq_next: got %b enq %b want 0100/0", oDeqAck, oPqEnq); end
    nTests++; if (oRspValid !== 4'b0100 || oRspKv !== {8'd1, 8'd11}) begin nFail++; $display("[TB] FAIL empty_rsp: got %b %h want 0100 010b", oRspValid, oRspKv); end
  endtask

  task automatic test_drain();
    logic [KW-1:0] keys[3];
    keys = '{8'd1, 8'd2, 8'd9};
    applyReset();
    setEnq(0, 8'd9, 8'd1); setEnq(1, 8'd1, 8'd2); setEnq(2, 8'd2, 8'd3);
    repeat (3) applyStimulus();
    deqReq = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      nTests++; if (oDeqAck !== 4'(1 << i) || oRspValid !== 4'(1 << i)) begin nFail++; $display("[TB] FAIL drain_order_%0d: got %b/%b want %b", i, oDeqAck, oRspValid, 4'(1 << i)); end
      nTests++; if (oRspKv[KVW-1 -: KW] !== keys[i]) begin nFail++; $display("[TB] FAIL drain_key_%0d: got %0d want %0d", i, oRspKv[KVW-1 -: KW], keys[i]); end
    end
    applyStimulus();
    nTests++; if (oDeqAck !== 4'b0000 || oPqDeq !== 1'b0 || oRspValid !== 4'b0000) begin nFail++; $display("[TB] FAIL drain_stall: got %b deq %b rsp %b want 0000/0/0000", oDeqAck, oPqDeq, oRspValid); end
    deqReq = '0;
  endtask

  task automatic test_reset_mid();
    applyReset();
    setEnq(0, 8'd5, 8'd5); setEnq(1, 8'd6, 8'd6); setEnq(2, 8'd7, 8'd7);
    repeat (3) applyStimulus();
    deqReq[2] = 1'b1;
    applyStimulus();
    deqReq[1] = 1'b1;
    driveQueueView();
    #2;
    nTests++; if (bus.pq_deq !== 1'b1) begin nFail++; $display("[TB] FAIL midrst_setup: got deq %b want 1", bus.pq_deq); end
    rst = 1'b1;
    #1;
    nTests++; if (bus.deq_rsp_valid !== 4'b0000) begin nFail++; $display("[TB] FAIL midrst_async: got %b want 0000", bus.deq_rsp_valid); end
    @(posedge clk); #1;
    nTests++; if (bus.deq_rsp_valid !== 4'b0000 || bus.count !== '0) begin nFail++; $display("[TB] FAIL midrst_clear: got %b count %0d want 0000/0", bus.deq_rsp_valid, bus.count); end
    modelReset();
    rst = 1'b0;
    setEnq(0, 8'd3, 8'd3); setEnq(1, 8'd3, 8'd3); setEnq(2, 8'd3, 8'd3); setEnq(3, 8'd3, 8'd3);
    applyStimulus();
    nTests++; if (oEnqAck !== 4'b0001) begin nFail++; $display("[TB] FAIL midrst_enq_ptr: got %b want 0001", oEnqAck); end
    deqReq = 4'b1111;
    applyStimulus();
    nTests++; if (oDeqAck !== 4'b0001) begin nFail++; $display("[TB] FAIL midrst_deq_ptr: got %b want 0001", oDeqAck); end
  endtask

  task automatic test_random();
    applyReset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (!enqReq[c] && $urandom_range(0, 3) == 0)
          setEnq(c, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        if (!deqReq[c] && $urandom_range(0, 3) == 0)
          deqReq[c] = 1'b1;
      end
      applyStimulus();
      nTests++; if (oEnqAck !== eEnqAck || oPqEnq !== eDoEnq) begin nFail++; $display("[TB] FAIL rand_enq @%0d: got %b/%b want %b/%b", cyc, oEnqAck, oPqEnq, eEnqAck, eDoEnq); end
      nTests++; if (oDeqAck !== eDeqAck || oPqDeq !== eDoDeq) begin nFail++; $display("[TB] FAIL rand_deq @%0d: got %b/%b want %b/%b", cyc, oDeqAck, oPqDeq, eDeqAck, eDoDeq); end
      if (eDoEnq || !eEnqFound) begin
        nTests++; if (oPqKvi !== ePqKvi) begin nFail++; $display("[TB] FAIL rand_kvi @%0d: got %h want %h", cyc, oPqKvi, ePqKvi); end
      end
      nTests++; if (oRspValid !== mRspValid || oRspKv !== mRspKv) begin nFail++; $display("[TB] FAIL rand_rsp @%0d: got %b %h want %b %h", cyc, oRspValid, oRspKv, mRspValid, mRspKv); end
      nTests++; if (oCount !== CW'(mQ.size())) begin nFail++; $display("[TB] FAIL rand_count @%0d: got %0d want %0d", cyc, oCount, mQ.size()); end
    end
  endtask

  initial begin
    rst = 1'b1;
    modelReset();
    test_reset();
    test_basic();
    test_rr_order();
    test_full();
    test_empty_both();
    test_drain();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/pq_rr_arb.md
Name: pq_rr_arb

Overview:
- Shares one priority-queue instance (pq_if style: kvi/enq/deq in; kvo/empty/full out) between N_CLIENTS requesters.
- Each cycle, independent round-robin arbiters pick at most one enqueue winner and one dequeue winner.
- Winners are issued to the queue as enq, deq or a combined enq+deq.
- Tracks occupancy and returns dequeued key/value pairs to the winning client one cycle later.

Parameters:
- N_CLIENTS, 4, number of requesters (2..16).
- DEPTH, 8, capacity of the attached queue; used only for the occupancy counter.
- KVW, KEY_WIDTH+VAL_WIDTH (from pq_pkg), width of one key/value word; key occupies the upper KEY_WIDTH bits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- enq_req  in  N_CLIENTS  per-client enqueue request; held until acked
- enq_kv  in  N_CLIENTS*KVW  per-client enqueue word; client i uses slice i
- enq_ack  out  N_CLIENTS  one-hot; combinational; enqueue accepted this cycle
- deq_req  in  N_CLIENTS  per-client dequeue request; held until acked
- deq_ack  out  N_CLIENTS  one-hot; combinational; dequeue issued this cycle
- deq_rsp_valid  out  N_CLIENTS  one-hot; registered; dequeued word is on deq_rsp_kv
- deq_rsp_kv  out  KVW  registered; word removed by the previous cycle's dequeue
- pq_kvi  out  KVW  to queue kvi
- pq_enq  out  1  to queue enq
- pq_deq  out  1  to queue deq
- pq_kvo  in  KVW  queue head (minimum key)
- pq_empty  in  1  queue empty
- pq_full  in  1  queue full
- count  out  $clog2(DEPTH+1)  registered occupancy

Behaviour:
- Reset (async, rst=1): enq_ptr=0, deq_ptr=0, count=0, deq_rsp_valid=0, deq_rsp_kv=0. Combinational outputs are 0 while no requests are present.
- Arbitration: two independent round-robin pointers.
  - Enqueue candidate = first i with enq_req[i], searching from enq_ptr upward with wrap mod N_CLIENTS. Dequeue candidate is chosen the same way from deq_ptr.
  - Pointer update: on grant to client g, ptr <= (g+1) mod N_CLIENTS. No grant leaves the pointer unchanged.
- Issue rules, evaluated in order:
  - do_deq = deq candidate exists AND !pq_empty.
  - do_enq = enq candidate exists AND (!pq_full OR do_deq). When full, a replace-style enq+deq is allowed.
  - Empty queue plus both requests: enq issues alone. The deq stays pending; enq and deq never issue together when pq_empty=1.
- Outputs from the issue rules:
  - pq_enq=do_enq; pq_deq=do_deq; pq_kvi=enq_kv slice of the enq winner (0 if none).
  - enq_ack[winner]=do_enq; deq_ack[winner]=do_deq.
  - The same client may win both in one cycle.
- Dequeue response:
  - On do_deq, capture deq_rsp_kv<=pq_kvo (head before removal).
  - Next cycle, deq_rsp_valid<=onehot(winner) for exactly 1 cycle; otherwise 0.
  - deq_rsp_kv holds its last value when not valid.
- Occupancy: count += do_enq - do_deq (both -> unchanged).
  - Never exceeds DEPTH nor goes below 0.
  - Consistency: count==0 iff pq_empty; count==DEPTH iff pq_full.
- Combinational latency: request to ack in the same cycle. Latency dequeue issue to response: 1 cycle.
- Clients must hold req and kv stable until ack; dropping req before ack is a protocol violation (not checked).
- Reset mid-operation: pointers, count and response are cleared immediately. Any in-flight response is lost. The attached queue is reset by the same rst.

Test Plan:
- Reset, then client 0 enq (key 8, val 14) -> enq_ack=0001, pq_enq=1 for 1 cycle, count=1; client 1 deq -> deq_ack=0010, next cycle deq_rsp_valid=0010, deq_rsp_kv={8,14}, count=0.
- Clients 0..3 all assert enq (keys 9,9,9,2) -> acks in order 0,1,2,3 on consecutive cycles, count=4; with 0 and 2 re-asserting at once after enq_ptr=0, client 0 wins first, then 2.
- Fill to DEPTH=8 -> pq_full=1, count=8; a further enq request alone gets no ack. The same enq plus a deq from another client issues enq+deq together; count stays 8 and the response is the old minimum.
- Empty queue, client 2 requests both enq(1,11) and deq -> cycle 1: enq only. Cycle 2: deq issues; response next cycle is {1,11}.
- Four deq requests on 3-entry queue (keys 1,2,9) -> responses keys 1,2,9 to clients 0,1,2 in order; client 3 stalls with no ack while empty.
- Assert rst during a cycle with do_deq=1 -> deq_rsp_valid stays 0, count=0, both pointers 0.
